// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32M multiply/divide unit.
//   XLEN        - operand/result width (32 only)
//   F3_*        - RV32M funct3 encodings
//   state_e     - muldiv_unit FSM state encoding
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request / writeback bundle between the register file side
// and the multiply/divide unit.
//   request : in_valid, funct3, read_data1, read_data2, Rd_in, kill
//   response: in_ready, busy, RegWrite, Rd, Write_data
//   modport slave  - the execute unit
//   modport master - the issuing pipeline / register file
interface muldiv_unit_if;
  import riscv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic [4:0]      Rd_in;
  logic            kill;
  logic            busy;
  logic            RegWrite;
  logic [4:0]      Rd;
  logic [XLEN-1:0] Write_data;

  modport slave (
    input  in_valid, funct3, read_data1, read_data2, Rd_in, kill,
    output in_ready, busy, RegWrite, Rd, Write_data
  );

  modport master (
    output in_valid, funct3, read_data1, read_data2, Rd_in, kill,
    input  in_ready, busy, RegWrite, Rd, Write_data
  );

endinterface

// File: rtl/muldiv_core_iter.sv
// muldiv_core_iter: shared 64-bit accumulator with one shift-add (multiply)
// or one restoring shift-subtract (divide) step per clock on magnitudes.
//   clk, reset  - clock, async active-high reset
//   load_i      - capture operands; acc = {0, opa}
//   step_i      - advance one iteration
//   is_div_i    - operation family captured at load
//   opa_i/opb_i - multiplicand-or-dividend / multiplier-or-divisor magnitudes
//   acc_next_o  - accumulator value after the current step
//                 (multiply: product; divide: {remainder, quotient})
module muldiv_core_iter
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   opa_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic [2*XLEN-1:0] acc_next_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic              is_div_q;

  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   diff;

  // One iteration of the selected datapath
  always_comb begin
    // multiply: add multiplier to the high half when the low bit is set,
    // then shift the 65-bit {carry, acc} right by one
    addend  = acc_q[0] ? opb_q : {XLEN{1'b0}};
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
    // divide: shift the partial remainder left, pulling in the next dividend bit
    shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge      = (shifted >= {1'b0, opb_q});
    // when ge holds the true difference is below 2^XLEN, so XLEN bits suffice
    diff    = shifted[XLEN-1:0] - opb_q;
    if (is_div_q) begin
      if (ge) begin
        acc_next_o = {diff, acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_next_o = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next_o = {sum, acc_q[XLEN-1:1]};
    end
  end

  // Operand capture and accumulator update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= {(2*XLEN){1'b0}};
      opb_q    <= {XLEN{1'b0}};
      is_div_q <= 1'b0;
    end else if (load_i) begin
      acc_q    <= {{XLEN{1'b0}}, opa_i};
      opb_q    <= opb_i;
      is_div_q <= is_div_i;
    end else if (step_i) begin
      acc_q    <= acc_next_o;
    end else begin
      acc_q    <= acc_q;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
//   clk, reset - clock, async active-high reset
//   bus        - muldiv_unit_if.slave: valid/ready request with funct3,
//                operands and Rd_in, kill flush, busy status and a one-cycle
//                RegWrite/Rd/Write_data writeback pulse.
// Flow: IDLE -accept-> CALC (32 iterations) -> DONE (strobe) -> IDLE.
// Divide-by-zero and signed overflow bypass CALC straight into DONE.
module muldiv_unit
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  state_e          state_q;
  logic [4:0]      cnt_q;
  logic [2:0]      op_q;
  logic            res_neg_q;
  logic [4:0]      rd_lat_q;
  logic            fired_q;
  logic            busy_q;
  logic            regwrite_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wdata_q;

  logic            accept;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            res_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_data;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic [XLEN-1:0] result;

  assign bus.in_ready   = (state_q == ST_IDLE) & ~bus.kill;
  assign bus.busy       = busy_q;
  assign bus.RegWrite   = regwrite_q;
  assign bus.Rd         = rd_q;
  assign bus.Write_data = wdata_q;

  assign accept = bus.in_valid & bus.in_ready;

  // Operand signedness per funct3 (MUL low word is sign-agnostic)
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: begin
        a_signed = 1'b1;
        b_signed = 1'b0;
      end
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
  end

  // Magnitudes, result sign and special-case detection at accept
  always_comb begin
    a_neg    = a_signed & bus.read_data1[XLEN-1];
    b_neg    = b_signed & bus.read_data2[XLEN-1];
    a_mag    = a_neg ? ({XLEN{1'b0}} - bus.read_data1) : bus.read_data1;
    b_mag    = b_neg ? ({XLEN{1'b0}} - bus.read_data2) : bus.read_data2;
    // remainder follows the dividend; products and quotients use the XOR
    res_neg  = (bus.funct3[2] & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div_op(bus.funct3) & (bus.read_data2 == {XLEN{1'b0}});
    // only signed DIV/REM (funct3[0] == 0) can overflow
    div_ovf  = is_div_op(bus.funct3) & ~bus.funct3[0] &
               (bus.read_data1 == 32'h8000_0000) & (bus.read_data2 == 32'hFFFF_FFFF);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_data = bus.funct3[1] ? bus.read_data1 : 32'hFFFF_FFFF;
    end else begin
      special_data = bus.funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  muldiv_core_iter u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept & ~special),
    .step_i     (state_q == ST_CALC),
    .is_div_i   (is_div_op(bus.funct3)),
    .opa_i      (a_mag),
    .opb_i      (b_mag),
    .acc_next_o (acc_next)
  );

  // Sign fixup and result selection on the final iteration's value
  always_comb begin
    prod_fix = res_neg_q ? ({(2*XLEN){1'b0}} - acc_next) : acc_next;
    quo_fix  = res_neg_q ? ({XLEN{1'b0}} - acc_next[XLEN-1:0]) : acc_next[XLEN-1:0];
    rem_fix  = res_neg_q ? ({XLEN{1'b0}} - acc_next[2*XLEN-1:XLEN]) : acc_next[2*XLEN-1:XLEN];
    case (op_q)
      F3_MUL:                        result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               result = quo_fix;
      F3_REM, F3_REMU:               result = rem_fix;
      default:                       result = {XLEN{1'b0}};
    endcase
  end

  // Control FSM with registered writeback outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 3'd0;
      res_neg_q  <= 1'b0;
      rd_lat_q   <= 5'd0;
      fired_q    <= 1'b0;
      busy_q     <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      wdata_q    <= {XLEN{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          regwrite_q <= 1'b0;
          fired_q    <= 1'b0;
          if (accept) begin
            op_q      <= bus.funct3;
            res_neg_q <= res_neg;
            rd_lat_q  <= bus.Rd_in;
            busy_q    <= 1'b1;
            cnt_q     <= 5'd0;
            if (special) begin
              state_q <= ST_DONE;
              wdata_q <= special_data;
              rd_q    <= bus.Rd_in;
            end else begin
              state_q <= ST_CALC;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (bus.kill) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 5'd0;
          end else if (cnt_q == 5'd31) begin
            state_q <= ST_DONE;
            wdata_q <= result;
            rd_q    <= rd_lat_q;
            cnt_q   <= 5'd0;
          end else begin
            cnt_q   <= cnt_q + 5'd1;
          end
        end
        ST_DONE: begin
          // first DONE edge raises the strobe, second drops it and frees the unit
          if (bus.kill) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            regwrite_q <= 1'b0;
            fired_q    <= 1'b0;
          end else if (!fired_q) begin
            regwrite_q <= (rd_q != 5'd0);
            fired_q    <= 1'b1;
          end else begin
            regwrite_q <= 1'b0;
            fired_q    <= 1'b0;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          regwrite_q <= 1'b0;
          fired_q    <= 1'b0;
          cnt_q      <= 5'd0;
        end
      endcase
    end
  end

endmodule
